// File: rtl/io_device.sv
// io_device: keyboard FIFO feeding INPR/FGI and OUTR/FGO display handshake FSMs.
// Define IO_DEVICE_OVERRUN_EN to add the saturating overrun_cnt output.
module io_device #(
  parameter int u = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         key_valid,
  input  logic [u-1:0] key_data,
  output logic         key_ready,
  output logic [u-1:0] datain,
  output logic         set_FGI,
  input  logic         FGI,
  input  logic [u-1:0] dataout,
  input  logic         FGO,
  output logic         set_FGO,
  output logic         disp_valid,
  output logic [u-1:0] disp_data,
  input  logic         disp_ready
`ifdef IO_DEVICE_OVERRUN_EN
  ,
  output logic [7:0]   overrun_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IN_IDLE, IN_LOAD, IN_WAIT} in_st_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_ACK, OUT_WAIT} out_st_e;
  in_st_e in_q, in_d;
  out_st_e out_q, out_d;
  logic [u-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [u-1:0] datain_q, disp_q;
  logic push, pop;

  assign key_ready = cnt_q != CW'(DEPTH);
  assign push = key_valid && key_ready;
  assign pop = in_q == IN_IDLE && cnt_q != '0 && !FGI;

  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= key_data;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      datain_q <= '0;
      disp_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q <= rd_q + AW'(1);
        datain_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (out_q == OUT_IDLE && !FGO) disp_q <= dataout;
    end

  // Output FSM resets into OUT_ACK so the display announces itself ready once.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      in_q <= IN_IDLE;
      out_q <= OUT_ACK;
    end else begin
      in_q <= in_d;
      out_q <= out_d;
    end

  always_comb begin
    in_d = in_q == IN_IDLE ? (pop ? IN_LOAD : IN_IDLE) :
           in_q == IN_LOAD ? IN_WAIT :
           (in_q == IN_WAIT && FGI) ? IN_WAIT : IN_IDLE;
    out_d = out_q == OUT_IDLE ? (FGO ? OUT_IDLE : OUT_SEND) :
            out_q == OUT_SEND ? (disp_ready ? OUT_ACK : OUT_SEND) :
            out_q == OUT_ACK  ? OUT_WAIT :
            FGO ? OUT_IDLE : OUT_WAIT;
  end

  always_comb begin
    set_FGI = in_q == IN_LOAD;
    datain = datain_q;
    disp_valid = out_q == OUT_SEND;
    set_FGO = out_q == OUT_ACK;
    disp_data = disp_q;
  end

`ifdef IO_DEVICE_OVERRUN_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) overrun_cnt <= '0;
    else if (key_valid && !key_ready && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_io_device.sv
// tb_io_device: directed scenarios plus randomized traffic against a queue-based model of io_device.
module tb_io_device;
  localparam int DEPTH = 4;
  logic CLK = 0;
  logic RST = 0;
  logic key_valid = 0;
  logic [7:0] key_data = 0;
  logic key_ready;
  logic [7:0] datain;
  logic set_FGI;
  logic FGI = 0;
  logic [7:0] dataout = 0;
  logic FGO = 1;
  logic set_FGO;
  logic disp_valid;
  logic [7:0] disp_data;
  logic disp_ready = 0;
  int total = 0;
  int bad = 0;
`ifdef IO_DEVICE_OVERRUN_EN
  logic [7:0] overrun_cnt;
  int exp_ovr = 0;
`endif

  io_device #(.u(8), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .datain(datain), .set_FGI(set_FGI), .FGI(FGI), .dataout(dataout), .FGO(FGO),
    .set_FGO(set_FGO), .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
`ifdef IO_DEVICE_OVERRUN_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // One clock; the CPU flag registers follow the set pulses seen before the edge.
  task automatic tick();
    logic sfgi, sfgo;
    sfgi = set_FGI;
    sfgo = set_FGO;
    @(posedge CLK);
    #1;
    if (sfgi) FGI = 1;
    if (sfgo) FGO = 1;
  endtask

  task automatic wait_load(output bit ok);
    ok = 0;
    for (int n = 0; n < 8 && !ok; n++) begin
      tick();
      ok = set_FGI;
    end
  endtask

  task automatic test_reset();
    #2 RST = 1;
    #1;
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset key_ready: got %b want 1", key_ready); end
    total++; if (datain !== 8'h00) begin bad++; $display("FAIL reset datain: got %h want 00", datain); end
    total++; if (set_FGI !== 1'b0) begin bad++; $display("FAIL reset set_FGI: got %b want 0", set_FGI); end
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset disp_valid: got %b want 0", disp_valid); end
    total++; if (disp_data !== 8'h00) begin bad++; $display("FAIL reset disp_data: got %h want 00", disp_data); end
`ifdef IO_DEVICE_OVERRUN_EN
    total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL reset overrun_cnt: got %0d want 0", overrun_cnt); end
`endif
    tick();
    tick();
    RST = 0;
    total++; if (set_FGO !== 1'b1) begin bad++; $display("FAIL release set_FGO: got %b want 1", set_FGO); end
    tick();
    total++; if (set_FGO !== 1'b0) begin bad++; $display("FAIL release set_FGO pulse width: got %b want 0", set_FGO); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (disp_valid !== 1'b0 || set_FGO !== 1'b0) begin bad++; $display("FAIL idle display: got valid=%b set_FGO=%b want 0 0", disp_valid, set_FGO); end
    end
  endtask

  task automatic test_key_latency();
    FGI = 0;
    key_valid = 1;
    key_data = 8'h41;
    tick();
    key_valid = 0;
    total++; if (set_FGI !== 1'b0) begin bad++; $display("FAIL latency early set_FGI: got %b want 0", set_FGI); end
    tick();
    total++; if (set_FGI !== 1'b1) begin bad++; $display("FAIL latency set_FGI: got %b want 1", set_FGI); end
    total++; if (datain !== 8'h41) begin bad++; $display("FAIL latency datain: got %h want 41", datain); end
    tick();
    total++; if (set_FGI !== 1'b0 || datain !== 8'h41) begin bad++; $display("FAIL set_FGI pulse: got %b/%h want 0/41", set_FGI, datain); end
    tick();
    tick();
    total++; if (set_FGI !== 1'b0 || datain !== 8'h41) begin bad++; $display("FAIL wait hold: got %b/%h want 0/41", set_FGI, datain); end
    FGI = 0;
    tick();
    tick();
    total++; if (set_FGI !== 1'b0 || datain !== 8'h41) begin bad++; $display("FAIL after read: got %b/%h want 0/41", set_FGI, datain); end
    key_valid = 1;
    key_data = 8'h42;
    tick();
    key_valid = 0;
    tick();
    total++; if (set_FGI !== 1'b1 || datain !== 8'h42) begin bad++; $display("FAIL second key: got %b/%h want 1/42", set_FGI, datain); end
    tick();
    FGI = 0;
    tick();
  endtask

  task automatic test_fifo_full();
    bit ok, seen;
    FGI = 1;
    for (int i = 0; i < 5; i++) begin
      total++; if (key_ready !== (i < 4)) begin bad++; $display("FAIL fill key_ready[%0d]: got %b want %b", i, key_ready, i < 4); end
      key_valid = 1;
      key_data = 8'(i + 1);
      tick();
    end
    key_valid = 0;
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL full key_ready: got %b want 0", key_ready); end
    total++; if (set_FGI !== 1'b0) begin bad++; $display("FAIL full set_FGI: got %b want 0", set_FGI); end
`ifdef IO_DEVICE_OVERRUN_EN
    exp_ovr = 1;
    total++; if (overrun_cnt !== 8'(exp_ovr)) begin bad++; $display("FAIL overrun_cnt: got %0d want %0d", overrun_cnt, exp_ovr); end
`endif
    FGI = 0;
    for (int k = 1; k <= 4; k++) begin
      wait_load(ok);
      total++; if (!ok) begin bad++; $display("FAIL drain timeout key %0d: got none want set_FGI", k); end
      total++; if (datain !== 8'(k)) begin bad++; $display("FAIL drain datain: got %h want %h", datain, 8'(k)); end
      tick();
      FGI = 0;
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= set_FGI;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL dropped key loaded: got set_FGI want none"); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL drained key_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_display();
    dataout = 8'h5A;
    FGO = 0;
    disp_ready = 0;
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL disp early: got %b want 0", disp_valid); end
    tick();
    total++; if (disp_valid !== 1'b1 || disp_data !== 8'h5A) begin bad++; $display("FAIL disp latency: got %b/%h want 1/5a", disp_valid, disp_data); end
    dataout = 8'hA5;
    tick();
    tick();
    total++; if (disp_valid !== 1'b1 || disp_data !== 8'h5A || set_FGO !== 1'b0) begin bad++; $display("FAIL disp hold: got %b/%h/%b want 1/5a/0", disp_valid, disp_data, set_FGO); end
    disp_ready = 1;
    tick();
    disp_ready = 0;
    total++; if (set_FGO !== 1'b1 || disp_valid !== 1'b0) begin bad++; $display("FAIL disp ack: got set_FGO=%b valid=%b want 1 0", set_FGO, disp_valid); end
    tick();
    total++; if (set_FGO !== 1'b0) begin bad++; $display("FAIL ack width: got %b want 0", set_FGO); end
    tick();
    tick();
    total++; if (disp_valid !== 1'b0 || set_FGO !== 1'b0) begin bad++; $display("FAIL disp repeat: got %b/%b want 0/0", disp_valid, set_FGO); end
  endtask

  task automatic test_reset_mid();
    bit seen, ok;
    FGI = 0;
    key_valid = 1;
    key_data = 8'h11;
    tick();
    key_data = 8'h22;
    tick();
    key_data = 8'h33;
    tick();
    key_valid = 0;
    total++; if (datain !== 8'h11 || set_FGI !== 1'b0) begin bad++; $display("FAIL pre-reset wait: got %h/%b want 11/0", datain, set_FGI); end
    dataout = 8'h77;
    FGO = 0;
    tick();
    total++; if (disp_valid !== 1'b1) begin bad++; $display("FAIL pre-reset send: got %b want 1", disp_valid); end
    #2 RST = 1;
    #1;
    total++; if (key_ready !== 1'b1 || datain !== 8'h00 || disp_valid !== 1'b0 || disp_data !== 8'h00 || set_FGI !== 1'b0) begin
      bad++; $display("FAIL mid reset: got rdy=%b din=%h dv=%b dd=%h sfgi=%b want 1 00 0 00 0", key_ready, datain, disp_valid, disp_data, set_FGI);
    end
    FGI = 0;
    FGO = 1;
    tick();
    tick();
    RST = 0;
    total++; if (set_FGO !== 1'b1) begin bad++; $display("FAIL mid release set_FGO: got %b want 1", set_FGO); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= set_FGI | disp_valid;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL stale handshake after reset: got activity want none"); end
    total++; if (datain !== 8'h00 || key_ready !== 1'b1) begin bad++; $display("FAIL post reset: got %h/%b want 00/1", datain, key_ready); end
`ifdef IO_DEVICE_OVERRUN_EN
    exp_ovr = 0;
    total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL overrun reset: got %0d want 0", overrun_cnt); end
`endif
    key_valid = 1;
    key_data = 8'h99;
    tick();
    key_valid = 0;
    wait_load(ok);
    total++; if (!ok || datain !== 8'h99) begin bad++; $display("FAIL fifo not empty after reset: got %b/%h want 1/99", ok, datain); end
    tick();
    FGI = 0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] oq[$];
    logic [7:0] last;
    bit busy, load_last, fgo_edge, exp_load, will_push, clr, drain;
    last = 8'h99;
    busy = 0;
    load_last = 0;
    fgo_edge = 1;
    for (int c = 0; c < 1600; c++) begin
      drain = c >= 1500;
      total++; if (key_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rnd key_ready c%0d: got %b want %b", c, key_ready, q.size() != DEPTH); end
      key_valid = !drain && $urandom_range(0, 1) == 1;
      key_data = 8'($urandom);
      if (FGI && $urandom_range(0, 2) == 0) FGI = 0;
      if (!drain && FGO && fgo_edge && $urandom_range(0, 3) == 0) begin
        dataout = 8'($urandom);
        FGO = 0;
        oq.push_back(dataout);
      end
      disp_ready = $urandom_range(0, 1) == 1;
      if (disp_valid) begin
        total++;
        if (oq.size() == 0) begin bad++; $display("FAIL rnd spurious disp_valid c%0d: got %h want none", c, disp_data); end
        else if (disp_data !== oq[0]) begin bad++; $display("FAIL rnd disp_data c%0d: got %h want %h", c, disp_data, oq[0]); end
        else if (disp_ready) void'(oq.pop_front());
      end
      will_push = key_valid && q.size() != DEPTH;
      exp_load = !busy && q.size() != 0 && !FGI;
      clr = busy && !load_last && !FGI;
`ifdef IO_DEVICE_OVERRUN_EN
      if (key_valid && q.size() == DEPTH && exp_ovr != 255) exp_ovr++;
`endif
      fgo_edge = FGO;
      tick();
      total++; if (set_FGI !== exp_load) begin bad++; $display("FAIL rnd set_FGI c%0d: got %b want %b", c, set_FGI, exp_load); end
      if (exp_load) last = q.pop_front();
      total++; if (datain !== last) begin bad++; $display("FAIL rnd datain c%0d: got %h want %h", c, datain, last); end
`ifdef IO_DEVICE_OVERRUN_EN
      total++; if (overrun_cnt !== 8'(exp_ovr)) begin bad++; $display("FAIL rnd overrun c%0d: got %0d want %0d", c, overrun_cnt, exp_ovr); end
`endif
      if (will_push) q.push_back(key_data);
      busy = exp_load ? 1'b1 : clr ? 1'b0 : busy;
      load_last = exp_load;
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd keys left: got %0d want 0", q.size()); end
    total++; if (oq.size() != 0) begin bad++; $display("FAIL rnd display chars left: got %0d want 0", oq.size()); end
  endtask

  initial begin
    test_reset();
    test_key_latency();
    test_fifo_full();
    test_display();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/io_device.md
IO_DEVICE -- requirements
Module: io_device

Interface
REQ-001 SHALL have parameter u, default 8, meaning the character width, matching the INPR/OUTR width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the keyboard FIFO depth; it is a power of two and at least 2.
REQ-003 SHALL have one clock and asynchronous active-high reset: CLK  in  1  rising-edge clock; RST  in  1  async active-high reset.
REQ-004 SHALL have port key_valid  in  1  keystroke offered.
REQ-005 SHALL have port key_data  in  u  keystroke code.
REQ-006 SHALL have port key_ready  out  1  FIFO can accept a keystroke.
REQ-007 SHALL have port datain  out  u  character driven to the CPU INPR.
REQ-008 SHALL have port set_FGI  out  1  one-cycle pulse that sets the CPU FGI flag.
REQ-009 SHALL have port FGI  in  1  CPU input flag (1 = INPR full, not yet read).
REQ-010 SHALL have port dataout  in  u  CPU OUTR contents.
REQ-011 SHALL have port FGO  in  1  CPU output flag (0 = OUTR holds a new character).
REQ-012 SHALL have port set_FGO  out  1  one-cycle pulse that sets the CPU FGO flag.
REQ-013 SHALL have port disp_valid  out  1  display character valid.
REQ-014 SHALL have port disp_data  out  u  display character.
REQ-015 SHALL have port disp_ready  in  1  display accepts the character.

Function
REQ-016 Keyboard FIFO SHALL push key_data when key_valid and key_ready are both 1 at a CLK edge; key_ready = (count != DEPTH), taken from registered count.
REQ-017 With the FIFO full, key_valid SHALL be ignored even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave count unchanged.
REQ-018 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-019 Input FSM SHALL use states IN_IDLE, IN_LOAD, IN_WAIT.
REQ-020 IN_IDLE -> IN_LOAD when the FIFO is non-empty and FGI == 0; on that edge the FIFO head SHALL be popped into the datain register.
REQ-021 IN_LOAD SHALL assert set_FGI for exactly one cycle with datain stable, then go to IN_WAIT.
REQ-022 IN_WAIT SHALL hold datain and return to IN_IDLE on the first cycle FGI == 0, meaning the CPU has read INPR; datain SHALL not change until the next IN_LOAD.
REQ-023 Output FSM SHALL use states OUT_IDLE, OUT_SEND, OUT_ACK, OUT_WAIT.
REQ-024 OUT_IDLE -> OUT_SEND when FGO == 0; dataout SHALL be captured into disp_data on that edge.
REQ-025 OUT_SEND SHALL assert disp_valid with disp_data stable until disp_ready == 1, then go to OUT_ACK.
REQ-026 OUT_ACK SHALL assert set_FGO for exactly one cycle, then go to OUT_WAIT.
REQ-027 OUT_WAIT -> OUT_IDLE when FGO == 1, so that one OUTR load yields exactly one display character.
REQ-028 Input and output FSMs SHALL run independently; concurrent activity SHALL not stall either FSM.
REQ-029 Latency SHALL be: key accepted into an empty FIFO -> set_FGI asserted 2 cycles later; FGO falling -> disp_valid asserted 1 cycle later.

Reset
REQ-030 RST high SHALL asynchronously set the FIFO empty, key_ready=1, datain=0, set_FGI=0, disp_valid=0, disp_data=0, and the input FSM to IN_IDLE.
REQ-031 RST SHALL place the output FSM in OUT_ACK, so set_FGO pulses once in the first cycle after reset release to declare the display ready.
REQ-032 RST asserted mid-transfer SHALL discard the FIFO contents and any pending display character without emitting a partial handshake.

Configuration
REQ-033 Macro IO_DEVICE_OVERRUN_EN, when defined, SHALL add output overrun_cnt (out, 8 bits), reset to 0, incrementing once per cycle with key_valid=1 and key_ready=0, and saturating at 255.
REQ-034 Without IO_DEVICE_OVERRUN_EN, the overrun_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Scenario: key 8'h41 pushed with FGI=0 -> set_FGI pulse 2 cycles later with datain=8'h41; model CPU sets FGI, then clears it -> FSM returns to IN_IDLE.
REQ-036 Scenario: 5 keys 8'h01..8'h05 pushed back-to-back while FGI is held 1 -> key_ready=0 after 4 keys, 8'h05 dropped; with IO_DEVICE_OVERRUN_EN, overrun_cnt=1.
REQ-037 Scenario: reset release -> set_FGO high for exactly 1 cycle; FGO held 1 -> no disp_valid.
REQ-038 Scenario: FGO driven 0 with dataout=8'h5A and disp_ready low for 3 cycles -> disp_valid held with disp_data=8'h5A; set_FGO pulses once, 1 cycle after disp_ready.
REQ-039 Scenario: RST asserted during IN_WAIT with 2 keys queued -> after release, FIFO empty, datain=0, and no set_FGI pulse.
